// File: rtl/arb_prio_rr_sched.sv
// Four-requester scheduler: priority arbitration with round-robin tie-break,
// held grants with a hold timeout, and aging that promotes starved requesters.
module arb_prio_rr_sched #(
  parameter int MAX_HOLD  = 16,
  parameter int AGE_LIMIT = 8
) (
  input  logic       arb_clk,
  input  logic       arb_rst_n,
  input  logic [3:0] arb_req,
  input  logic [7:0] arb_prio,
  input  logic [3:0] arb_done,
  output logic       arb_gnt_vld,
  output logic [1:0] arb_gnt,
  output logic [3:0] arb_gnt_oh,
  output logic       arb_timeout,
  output logic [1:0] pointer,
  output logic       arb_state_dbg
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int AW = $clog2(AGE_LIMIT + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [AW-1:0] AGE_MAX  = AW'(AGE_LIMIT);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t        r_state;
  logic          r_gnt_vld;
  logic [1:0]    r_gnt;
  logic [3:0]    r_gnt_oh;
  logic          r_timeout;
  logic [1:0]    r_pointer;
  logic [HW-1:0] r_hold;
  logic [AW-1:0] r_age [4];

  logic [1:0] w_max_prio;
  logic [3:0] w_prio_match;
  logic [3:0] w_starved;
  logic [3:0] w_cand;
  logic [1:0] w_winner;
  logic       w_win_found;
  logic       w_grant_now;
  logic       w_own_done;
  logic       w_own_drop;
  logic       w_hold_max;
  logic       w_release;

  // Candidate set: starved requesters override priority entirely.
  always_comb begin
    w_max_prio   = 2'd0;
    w_prio_match = 4'b0000;
    w_starved    = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (arb_req[i] && (arb_prio[2*i +: 2] > w_max_prio)) begin
        w_max_prio = arb_prio[2*i +: 2];
      end
    end
    for (int i = 0; i < 4; i++) begin
      w_prio_match[i] = arb_req[i] && (arb_prio[2*i +: 2] == w_max_prio);
      w_starved[i]    = arb_req[i] && (r_age[i] >= AGE_MAX);
    end
    w_cand = (|w_starved) ? w_starved : w_prio_match;
  end

  // Round-robin scan starting one past the most recent winner.
  always_comb begin
    logic [1:0] idx;
    idx         = 2'd0;
    w_winner    = 2'd0;
    w_win_found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = r_pointer + 2'(k);
      if (!w_win_found && w_cand[idx]) begin
        w_win_found = 1'b1;
        w_winner    = idx;
      end
    end
  end

  // Grant handshake: the owner keeps the resource from the cycle arb_gnt_vld
  // rises until it pulses its arb_done bit or drops arb_req; MAX_HOLD is the
  // backstop. Release is seen one edge later and a new grant one edge after that.
  assign w_grant_now = (r_state == S_IDLE) && (|arb_req);
  assign w_own_done  = arb_done[r_gnt];
  assign w_own_drop  = !arb_req[r_gnt];
  assign w_hold_max  = (r_hold == HOLD_MAX);
  assign w_release   = w_own_done || w_own_drop || w_hold_max;

  always_ff @(posedge arb_clk or negedge arb_rst_n) begin
    if (!arb_rst_n) begin
      r_state   <= S_IDLE;
      r_gnt_vld <= 1'b0;
      r_gnt     <= 2'b00;
      r_gnt_oh  <= 4'b0000;
      r_timeout <= 1'b0;
      r_pointer <= 2'b11;
      r_hold    <= '0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_now) begin
            r_state   <= S_GRANT;
            r_gnt_vld <= 1'b1;
            r_gnt     <= w_winner;
            r_gnt_oh  <= 4'b0001 << w_winner;
            r_pointer <= w_winner;
            r_hold    <= HW'(1);
          end
        end
        S_GRANT: begin
          if (w_release) begin
            r_state   <= S_IDLE;
            r_gnt_vld <= 1'b0;
            r_gnt_oh  <= 4'b0000;
            r_timeout <= w_hold_max && !w_own_done && !w_own_drop;
          end else begin
            r_hold <= r_hold + HW'(1);
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_gnt_vld <= 1'b0;
          r_gnt_oh  <= 4'b0000;
        end
      endcase
    end
  end

  // Owners (current, or the one being granted this edge) never age.
  always_ff @(posedge arb_clk or negedge arb_rst_n) begin
    if (!arb_rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_age[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!arb_req[i]) begin
          r_age[i] <= '0;
        end else if (w_grant_now && (w_winner == 2'(i))) begin
          r_age[i] <= '0;
        end else if ((r_state == S_GRANT) && (r_gnt == 2'(i))) begin
          r_age[i] <= r_age[i];
        end else if (r_age[i] < AGE_MAX) begin
          r_age[i] <= r_age[i] + AW'(1);
        end
      end
    end
  end

  assign arb_gnt_vld   = r_gnt_vld;
  assign arb_gnt       = r_gnt;
  assign arb_gnt_oh    = r_gnt_oh;
  assign arb_timeout   = r_timeout;
  assign pointer       = r_pointer;
  assign arb_state_dbg = (r_state == S_GRANT);

endmodule

// File: doc/arb_prio_rr_sched.md
# arb_prio_rr_sched

Four-requester resource scheduler that shares one resource among requesters using priority plus round-robin tie-break.
- A requester with higher 2-bit priority wins.
- Among equal priorities, the requester after the last winner wins.
- A grant is held until the owner signals done, drops its request, or hits a hold timeout.
- Per-requester aging counters promote starved requesters above all priorities.

The block sits in front of the shared resource. Its registered grant drives the resource mux select.

## Interface
Parameters:
- MAX_HOLD, 16: maximum grant length in cycles. Legal range 2..255.
- AGE_LIMIT, 8: waiting cycles after which a requester is starved. Legal range 1..255.

Ports:
- arb_clk, input, 1: single clock, rising edge.
- arb_rst_n, input, 1: reset, asynchronous, active-low.
- arb_req, input, 4: request vector. Bit i belongs to requester i.
- arb_prio, input, 8: priority of requester i on [2i+1:2i]. 3 is highest. Sampled only at arbitration.
- arb_done, input, 4: owner release strobe. Only the bit of the current owner is honoured.
- arb_gnt_vld, output, 1: a grant is active.
- arb_gnt, output, 2: index of the owner. Valid only while arb_gnt_vld is high.
- arb_gnt_oh, output, 4: one-hot owner. All zero when there is no grant.
- arb_timeout, output, 1: one-cycle pulse when a grant is forcibly ended by MAX_HOLD.
- pointer, output, 2: index of the most recent winner. Round-robin search starts at pointer+1, modulo 4.

## Operation
- Reset values: arb_gnt_vld=0, arb_gnt=2'b00, arb_gnt_oh=4'b0000, arb_timeout=0, pointer=2'b11 (so the first search starts at requester 0), hold counter=0, all age counters=0, state=IDLE.
- FSM states are IDLE and GRANT.
- IDLE:
  - If arb_req is nonzero, select a winner, register it, and go to GRANT.
  - Otherwise stay in IDLE.
- Winner selection (combinational, evaluated in IDLE):
  1. If any requesting index has age ≥ AGE_LIMIT, the candidate set is the starved requesters only.
  2. Otherwise the candidate set is the requesters with the maximum arb_prio among those requesting.
  3. Within the candidate set, pick the first index found scanning pointer+1, pointer+2, … with 2-bit wrap.
- On each grant:
  - pointer <= winner.
  - Hold counter <= 1.
  - The winner's age counter is cleared.
- GRANT:
  - The owner keeps the grant. Requests and priority changes from others are ignored.
  - The hold counter increments each cycle.
  - Exit to IDLE when any of these is true:
    - arb_done[owner]=1.
    - arb_req[owner]=0.
    - The hold counter equals MAX_HOLD. In this case only, assert arb_timeout for that cycle, unless done or request-drop also occurs in the same cycle.
  - On exit: arb_gnt_vld=0, arb_gnt_oh=0. arb_gnt keeps its last value.
- Age counters:
  - Every cycle, for each i ≠ current or new owner with arb_req[i]=1, age[i] increments and saturates at AGE_LIMIT.
  - age[i] clears when arb_req[i]=0 or when i is granted.
- arb_done bits of non-owners are ignored in all states.
- Width rules:
  - The hold counter is $clog2(MAX_HOLD+1) bits.
  - Age counters are $clog2(AGE_LIMIT+1) bits and saturate, never wrap.

## Timing
- Grant latency: a request visible before edge N while in IDLE gives arb_gnt_vld=1 after edge N.
- Release: done or request-drop sampled at edge M gives arb_gnt_vld=0 after M.
- Minimum one IDLE cycle between grants. The next earliest grant is after M+1.
- Back-to-back full-length grants occupy MAX_HOLD+1 cycles per grant.
- The timeout grant is high for exactly MAX_HOLD cycles. arb_timeout goes high on the cycle after the last grant cycle, together with arb_gnt_vld=0.
- All outputs are registered. No combinational input-to-output path.
- Reset asserted mid-grant immediately forces every output to its reset value, asynchronously. Arbitration restarts from requester 0 after release.
- Request and done arriving in the same cycle as the grant edge: done is ignored until the grant is visible. It is evaluated from the first GRANT cycle onward.

## Test plan
- Reset and first grant:
  - Stimulus: release reset, then arb_req=4'b1111 with all prio=0 and done pulsed each grant.
  - Required: grants in order 0,1,2,3,0, with one idle cycle between grants, and pointer tracks the winner.
- Priority:
  - Stimulus: arb_req=4'b1010, prio1=1, prio3=2.
  - Required: requester 3 wins repeatedly.
  - Then set prio1=2; required: grants alternate 1,3 (pointer-based tie-break).
- Timeout:
  - Stimulus: MAX_HOLD=16, requester 2 holds its request and never asserts done.
  - Required: arb_gnt_vld is high for 16 cycles, then arb_timeout pulses once with vld=0, then requester 2 is regranted one cycle later.
- Aging:
  - Stimulus: AGE_LIMIT=8, requester 0 at prio 0, requester 1 at prio 3 requesting continuously, each grant lasting 5 cycles.
  - Required: requester 0 is granted no later than the second arbitration after its age reaches 8, overriding requester 1.
- Release variants:
  - Stimulus: the owner drops arb_req without done, and a non-owner pulses arb_done.
  - Required: the request drop ends the grant the next cycle; the non-owner done has no effect.
- Reset mid-grant:
  - Stimulus: assert arb_rst_n=0 during GRANT, asynchronously between edges.
  - Required: arb_gnt_vld and arb_gnt_oh go to 0 immediately, and pointer=2'b11.
  - After release with arb_req=4'b1111, the first grant is to requester 0.
